// File: rtl/benes_pkg.sv
// Shared sizing, types and helpers for the Benes network configuration loader.
package benes_pkg;

  localparam int N_STAGE   = 7;
  localparam int N_SW      = 8;
  localparam int STAGE_LAT = 2;

  localparam int STAGE_W = $clog2(N_STAGE + 1);
  localparam int CNT_MAX = (N_STAGE - 1) * STAGE_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef logic [N_SW-1:0] sw_row_t;

  typedef enum logic {
    IDLE,
    SKEW
  } cfg_state_t;

  // Skew-counter value at which row s takes its new word.
  function automatic logic [CNT_W-1:0] row_slot(input int s);
    return CNT_W'(s * STAGE_LAT);
  endfunction

endpackage

// File: rtl/benes_cfg_shadow.sv
// Shadow bank of per-stage switch words, with a per-row loaded mask.
// The caller only presents legal row indices on the write port.
module benes_cfg_shadow
  import benes_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en_i,
  input  logic [STAGE_W-1:0]      wr_stage_i,
  input  sw_row_t                 wr_bits_i,
  input  logic                    clr_mask_i,
  output sw_row_t [N_STAGE-1:0]   rows_o,
  output logic                    full_o
);

  sw_row_t [N_STAGE-1:0] rows_q;
  logic    [N_STAGE-1:0] mask_q;

  // Capture written rows and remember which rows have been loaded since the last commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q <= '0;
      mask_q <= '0;
    end else begin
      if (clr_mask_i) begin
        mask_q <= '0;
      end
      if (wr_en_i) begin
        rows_q[wr_stage_i] <= wr_bits_i;
        mask_q[wr_stage_i] <= 1'b1;
      end
    end
  end

  assign rows_o = rows_q;
  assign full_o = &mask_q;

endmodule

// File: rtl/benes_cfg_loader.sv
// Configuration loader for the 16x16 Benes network: shadow writes, then a commit
// that rolls the shadow into the active rows one stage at a time, following the
// data wavefront so every wavefront sees a single consistent configuration.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | shadow writable, commit accepted when every row is loaded
//   SKEW  | shadow frozen, row s copied when cnt reaches s*STAGE_LAT
module benes_cfg_loader
  import benes_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [STAGE_W-1:0]            cfg_stage,
  input  logic [N_SW-1:0]               cfg_bits,
  input  logic                          cfg_commit,
  output logic                          commit_ack,
  output logic                          busy,
  output logic                          cfg_err,
  output logic [N_STAGE-1:0][N_SW-1:0]  switch_set
);

  cfg_state_t            state_q;
  logic [CNT_W-1:0]      cnt_q;
  sw_row_t [N_STAGE-1:0] shadow;
  logic                  mask_full;
  logic                  wr_acc;
  logic                  wr_legal;
  logic                  last_slot;

  // A commit request blocks the same-cycle write so the mask check sees a stable bank.
  assign cfg_ready = (state_q == IDLE) && !cfg_commit;
  assign wr_acc    = cfg_valid && cfg_ready;
  assign wr_legal  = int'(cfg_stage) < N_STAGE;
  assign last_slot = (state_q == SKEW) && (cnt_q == CNT_W'(CNT_MAX));

  benes_cfg_shadow u_shadow (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (wr_acc && wr_legal),
    .wr_stage_i (cfg_stage),
    .wr_bits_i  (cfg_bits),
    .clr_mask_i (last_slot),
    .rows_o     (shadow),
    .full_o     (mask_full)
  );

  // Commit FSM, skew counter and the active row registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      switch_set <= '0;
      commit_ack <= 1'b0;
      busy       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      commit_ack <= 1'b0;
      // Lags the state by one cycle so busy covers every row-update cycle.
      busy       <= (state_q == SKEW);
      case (state_q)
        IDLE: begin
          if (wr_acc && !wr_legal) begin
            cfg_err <= 1'b1;
          end
          if (cfg_commit) begin
            if (mask_full) begin
              state_q <= SKEW;
              cnt_q   <= '0;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        SKEW: begin
          for (int s = 0; s < N_STAGE; s++) begin
            if (cnt_q == row_slot(s)) begin
              switch_set[s] <= shadow[s];
            end
          end
          if (last_slot) begin
            commit_ack <= 1'b1;
            cfg_err    <= 1'b0;
            state_q    <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
